// File: rtl/in_port_fifo.sv
// in_port_fifo: valid/ready capture FIFO feeding the processor portIn, first-word-fall-through.
// Optional IN_PORT_HOLD_LAST_EN: when empty, port_in repeats the last popped word instead of 0.
module in_port_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_ext_data,
  input  logic             i_ext_valid,
  output logic             o_ext_ready,
  input  logic             i_in_rd,
  output logic [WIDTH-1:0] o_port_in,
  output logic             o_in_empty,
  output logic             o_in_stall,
  output logic             o_in_underflow,
  output logic [AW:0]      o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_underflow;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  // full/empty come only from the registered count, never from this cycle's inputs
  assign w_full  = r_count == (AW+1)'(DEPTH);
  assign w_empty = r_count == '0;
  assign w_push  = i_ext_valid && !w_full;
  assign w_pop   = i_in_rd && !w_empty;
  assign w_head  = r_mem[r_rd_ptr];
  assign o_ext_ready    = !w_full;
  assign o_in_empty     = w_empty;
  assign o_in_stall     = i_in_rd && w_empty;
  assign o_in_underflow = r_underflow;
  assign o_count        = r_count;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_ext_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= (w_push && !w_pop) ? r_count + (AW+1)'(1) :
                 (w_pop && !w_push) ? r_count - (AW+1)'(1) : r_count;
      if (i_in_rd && w_empty) r_underflow <= 1'b1;
    end
  end
`ifdef IN_PORT_HOLD_LAST_EN
  logic [WIDTH-1:0] r_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last <= '0;
    else if (w_pop) r_last <= w_head;
  end
  assign o_port_in = w_empty ? r_last : w_head;
`else
  assign o_port_in = w_empty ? '0 : w_head;
`endif
endmodule

// File: tb/tb_in_port_fifo.sv
// tb_in_port_fifo: directed checks of reset, FWFT read, backpressure, wrap, underflow and async reset.
module tb_in_port_fifo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ext_data;
  logic        ext_valid;
  logic        ext_ready;
  logic        in_rd;
  logic [15:0] port_in;
  logic        in_empty;
  logic        in_stall;
  logic        in_underflow;
  logic [2:0]  count;
  int          n_checks = 0;
  int          n_fail = 0;
  in_port_fifo #(.WIDTH(16), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_ext_data(ext_data), .i_ext_valid(ext_valid),
    .o_ext_ready(ext_ready), .i_in_rd(in_rd), .o_port_in(port_in), .o_in_empty(in_empty),
    .o_in_stall(in_stall), .o_in_underflow(in_underflow), .o_count(count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; ext_data = '0; ext_valid = 1'b0; in_rd = 1'b1;
    #1;
    n_checks++; if (in_stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall got %b exp 1", in_stall); end
    tick(); tick();
    in_rd = 1'b0;
    #1;
    n_checks++; if (ext_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_in got %b exp 1", ext_ready); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
    n_checks++; if (in_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b exp 1", in_empty); end
    n_checks++; if (ext_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", ext_ready); end
    n_checks++; if (port_in !== 16'h0000) begin n_fail++; $display("FAIL rst_port got %h exp 0000", port_in); end
    n_checks++; if (in_underflow !== 1'b0) begin n_fail++; $display("FAIL rst_uflow got %b exp 0", in_underflow); end
  endtask
  task automatic test_single();
    logic [15:0] exp_empty;
`ifdef IN_PORT_HOLD_LAST_EN
    exp_empty = 16'h00DA;
`else
    exp_empty = 16'h0000;
`endif
    ext_data = 16'h00DA; ext_valid = 1'b1;
    #1;
    n_checks++; if (port_in !== 16'h0000) begin n_fail++; $display("FAIL single_nobypass got %h exp 0000", port_in); end
    tick();
    ext_valid = 1'b0;
    n_checks++; if (port_in !== 16'h00DA) begin n_fail++; $display("FAIL single_head got %h exp 00DA", port_in); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", count); end
    in_rd = 1'b1;
    #1;
    n_checks++; if (in_stall !== 1'b0) begin n_fail++; $display("FAIL single_stall got %b exp 0", in_stall); end
    tick();
    in_rd = 1'b0;
    n_checks++; if (in_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got %b exp 1", in_empty); end
    n_checks++; if (port_in !== exp_empty) begin n_fail++; $display("FAIL single_port_empty got %h exp %h", port_in, exp_empty); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count0 got %0d exp 0", count); end
  endtask
  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      ext_data = 16'(i); ext_valid = 1'b1;
      #1;
      n_checks++; if (ext_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_%0d got %b exp 1", i, ext_ready); end
      tick();
    end
    ext_data = 16'h0005;
    n_checks++; if (ext_ready !== 1'b0) begin n_fail++; $display("FAIL full_notready got %b exp 0", ext_ready); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", count); end
    tick();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_hold_count got %0d exp 4", count); end
    n_checks++; if (port_in !== 16'h0001) begin n_fail++; $display("FAIL full_head got %h exp 0001", port_in); end
    in_rd = 1'b1;
    tick();
    in_rd = 1'b0;
    n_checks++; if (port_in !== 16'h0002) begin n_fail++; $display("FAIL full_pop_head got %h exp 0002", port_in); end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count got %0d exp 3", count); end
    n_checks++; if (ext_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_again got %b exp 1", ext_ready); end
    tick();
    ext_valid = 1'b0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_refill got %0d exp 4", count); end
    for (int i = 2; i <= 5; i++) begin
      n_checks++; if (port_in !== 16'(i)) begin n_fail++; $display("FAIL full_drain_%0d got %h exp %h", i, port_in, 16'(i)); end
      in_rd = 1'b1;
      tick();
    end
    in_rd = 1'b0;
    n_checks++; if (in_empty !== 1'b1) begin n_fail++; $display("FAIL full_drained got %b exp 1", in_empty); end
  endtask
  task automatic test_wrap();
    logic [15:0] exp_q [$];
    exp_q = {16'h00A0, 16'h00A1};
    for (int i = 0; i < 2; i++) begin
      ext_data = exp_q[i]; ext_valid = 1'b1;
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      ext_data = 16'h0100 + 16'(i); ext_valid = 1'b1; in_rd = 1'b1;
      exp_q.push_back(16'h0100 + 16'(i));
      #1;
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL wrap_count_%0d got %0d exp 2", i, count); end
      n_checks++; if (port_in !== exp_q[0]) begin n_fail++; $display("FAIL wrap_order_%0d got %h exp %h", i, port_in, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    ext_valid = 1'b0;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL wrap_count_end got %0d exp 2", count); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (port_in !== 16'h0108 + 16'(i)) begin n_fail++; $display("FAIL wrap_tail_%0d got %h exp %h", i, port_in, 16'h0108 + 16'(i)); end
      tick();
    end
    in_rd = 1'b0;
    n_checks++; if (in_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b exp 1", in_empty); end
  endtask
  task automatic test_underflow();
    in_rd = 1'b1;
    #1;
    n_checks++; if (in_stall !== 1'b1) begin n_fail++; $display("FAIL uf_stall0 got %b exp 1", in_stall); end
    n_checks++; if (in_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_pre got %b exp 0", in_underflow); end
    tick();
    n_checks++; if (in_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set got %b exp 1", in_underflow); end
    n_checks++; if (in_stall !== 1'b1) begin n_fail++; $display("FAIL uf_stall1 got %b exp 1", in_stall); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL uf_count got %0d exp 0", count); end
    tick();
    in_rd = 1'b0;
    #1;
    n_checks++; if (in_stall !== 1'b0) begin n_fail++; $display("FAIL uf_stall_off got %b exp 0", in_stall); end
    n_checks++; if (in_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky got %b exp 1", in_underflow); end
    ext_data = 16'h0055; ext_valid = 1'b1;
    tick();
    ext_valid = 1'b0;
    n_checks++; if (port_in !== 16'h0055) begin n_fail++; $display("FAIL uf_ptrs got %h exp 0055", port_in); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL uf_push_count got %0d exp 1", count); end
  endtask
  task automatic test_reset_mid();
    ext_data = 16'h0011; ext_valid = 1'b1;
    tick();
    ext_data = 16'h0022;
    tick();
    ext_valid = 1'b0;
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count got %0d exp 3", count); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count got %0d exp 0", count); end
    n_checks++; if (in_empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty got %b exp 1", in_empty); end
    n_checks++; if (in_underflow !== 1'b0) begin n_fail++; $display("FAIL mid_uflow got %b exp 0", in_underflow); end
    n_checks++; if (port_in !== 16'h0000) begin n_fail++; $display("FAIL mid_port got %h exp 0000", port_in); end
    tick();
    rst_n = 1'b1;
    ext_data = 16'hBEEF; ext_valid = 1'b1;
    tick();
    ext_valid = 1'b0;
    n_checks++; if (port_in !== 16'hBEEF) begin n_fail++; $display("FAIL mid_head got %h exp BEEF", port_in); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL mid_post_count got %0d exp 1", count); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_underflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
